// File: rtl/mul_share_arb_if.sv
// Request/response bundle for the shared-multiplier arbiter.
// The slave side is the arbiter; the master side drives requests and takes results.
interface mul_share_arb_if #(
  parameter int W = 8
) ();
  logic [3:0]     req_valid;
  logic [4*W-1:0] req_a;
  logic [4*W-1:0] req_b;
  logic [3:0]     req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] rsp_y;
  logic [1:0]     rsp_id;
  logic           busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_id, busy
  );
endinterface

// File: rtl/mul_share_arb.sv
// Four requesters time-share one unsigned W x W multiplier.
// A round-robin winner is accepted in IDLE, multiplied in CALC and held in
// RESP until the downstream takes it. ptr remembers the last completed grant.
module mul_share_arb #(
  parameter int W = 8
) (
  input logic          clk,
  input logic          rst,
  mul_share_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     ptr_q;
  logic [W-1:0]   a_q, b_q;
  logic [1:0]     id_q;
  logic [2*W-1:0] rsp_y_q;
  logic [1:0]     rsp_id_q;

  logic           grant_found;
  logic [1:0]     grant_idx;
  logic [3:0]     grant_oh;
  logic           accept;
  logic [W-1:0]   sel_a, sel_b;

  // Round-robin search: first valid requester starting just after ptr.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!grant_found && bus.req_valid[ptr_q + 2'(k)]) begin
        grant_found = 1'b1;
        grant_idx   = ptr_q + 2'(k);
      end
    end
  end

  assign grant_oh = 4'b0001 << grant_idx;
  assign accept   = (state_q == IDLE) && !rst && grant_found;
  assign sel_a    = bus.req_a[grant_idx*W +: W];
  assign sel_b    = bus.req_b[grant_idx*W +: W];

  // Next-state logic for the IDLE -> CALC -> RESP loop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; reset discards any in-flight transaction.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd3;
      rsp_y_q  <= '0;
      rsp_id_q <= 2'd0;
      id_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      if (accept) id_q <= grant_idx;
      if (state_q == CALC) begin
        rsp_y_q  <= {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
        rsp_id_q <= id_q;
      end
      if (state_q == RESP && bus.rsp_ready) ptr_q <= rsp_id_q;
    end
  end

  // Operand capture at acceptance so later bus changes cannot reach the product.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath holding registers need no reset; they are always written before being used.
    if (accept) begin
      a_q <= sel_a;
      b_q <= sel_b;
    end
  end

  assign bus.req_ready = accept ? grant_oh : 4'b0000;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: table of single transactions plus hand-written
// sequences for fairness, backpressure, mid-operation reset and skipping.
module tb_mul_share_arb;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_share_arb_if #(.W(W)) bus ();

  mul_share_arb #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total  = 0;
  int n_passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance past the next rising edge; inputs are driven here, outputs checked 1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]     vld;
    logic [4*W-1:0] a;
    logic [4*W-1:0] b;
    logic [3:0]     exp_ready;
    logic [1:0]     exp_id;
    logic [2*W-1:0] exp_y;
  } vec_t;

  vec_t vecs [7];

  initial begin
    // Table: ptr before each vector is 3,0,2,3,1,3,0 (chained from previous winner).
    vecs[0] = '{4'b0001, 32'h0000000C, 32'h0000000A, 4'b0001, 2'd0, 16'h0078};
    vecs[1] = '{4'b0100, 32'h11FF2233, 32'h44FF5566, 4'b0100, 2'd2, 16'hFE01};
    vecs[2] = '{4'b1111, 32'h00AABBCC, 32'h37010203, 4'b1000, 2'd3, 16'h0000};
    vecs[3] = '{4'b1010, 32'h99000F00, 32'h77001100, 4'b0010, 2'd1, 16'h00FF};
    vecs[4] = '{4'b1001, 32'h80000005, 32'h02000006, 4'b1000, 2'd3, 16'h0100};
    vecs[5] = '{4'b0001, 32'h000000FF, 32'h00000001, 4'b0001, 2'd0, 16'h00FF};
    vecs[6] = '{4'b0001, 32'h00000003, 32'h00000005, 4'b0001, 2'd0, 16'h000F};

    bus.req_valid = 4'b1111;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset state, with requests pending that must not be granted.
    tick();
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_y",     32'(bus.rsp_y),     32'h0);
    check("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
    check("rst_busy",      32'(bus.busy),      32'h0);
    rst = 1'b0;
    bus.req_valid = 4'b0000;
    tick();

    // Fairness: all four requesting, rsp_ready tied high -> 0,1,2,3,0,1,2,3.
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("fair_grant%0d", i), 32'(bus.req_ready), 32'(4'b0001 << (i % 4)));
      tick();
      tick();
      #1;
      check($sformatf("fair_id%0d", i), 32'(bus.rsp_id), 32'(i % 4));
      tick();
    end

    // Table-driven single transactions; operands are inverted after capture.
    for (int v = 0; v < 7; v++) begin
      bus.req_valid = vecs[v].vld;
      bus.req_a     = vecs[v].a;
      bus.req_b     = vecs[v].b;
      bus.rsp_ready = 1'b1;
      #1;
      check($sformatf("v%0d_grant", v), 32'(bus.req_ready), 32'(vecs[v].exp_ready));
      check($sformatf("v%0d_idle_busy", v), 32'(bus.busy), 32'h0);
      tick();
      bus.req_valid = 4'b0000;
      bus.req_a     = ~vecs[v].a;
      bus.req_b     = ~vecs[v].b;
      #1;
      check($sformatf("v%0d_calc_busy", v), 32'(bus.busy), 32'h1);
      check($sformatf("v%0d_calc_valid", v), 32'(bus.rsp_valid), 32'h0);
      tick();
      #1;
      check($sformatf("v%0d_valid", v), 32'(bus.rsp_valid), 32'h1);
      check($sformatf("v%0d_y", v), 32'(bus.rsp_y), 32'(vecs[v].exp_y));
      check($sformatf("v%0d_id", v), 32'(bus.rsp_id), 32'(vecs[v].exp_id));
      check($sformatf("v%0d_resp_ready", v), 32'(bus.req_ready), 32'h0);
      tick();
      #1;
      check($sformatf("v%0d_done_valid", v), 32'(bus.rsp_valid), 32'h0);
    end

    // Backpressure: ptr=0, requester 1 wins, result held for 5 stalled cycles.
    bus.req_valid = 4'b0010;
    bus.req_a     = 32'h00002300;
    bus.req_b     = 32'h00000400;
    #1;
    check("bp_grant", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b1111;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp_valid%0d", c), 32'(bus.rsp_valid), 32'h1);
      check($sformatf("bp_y%0d", c),     32'(bus.rsp_y),     32'h008C);
      check($sformatf("bp_id%0d", c),    32'(bus.rsp_id),    32'h1);
      check($sformatf("bp_ready%0d", c), 32'(bus.req_ready), 32'h0);
      check($sformatf("bp_busy%0d", c),  32'(bus.busy),      32'h1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_valid", 32'(bus.rsp_valid), 32'h1);
    tick();
    // Same IDLE cycle as the drop of rsp_valid: ptr=1, so requester 2 wins.
    #1;
    check("bp_after_valid", 32'(bus.rsp_valid), 32'h0);
    check("bp_after_grant", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    #1;
    check("bp_second_id", 32'(bus.rsp_id), 32'h2);
    check("bp_second_y",  32'(bus.rsp_y),  32'h0);
    tick();

    // Mid-operation reset: ptr=2, requester 0 accepted, reset during CALC.
    bus.req_valid = 4'b0001;
    bus.req_a     = 32'h00000009;
    bus.req_b     = 32'h00000009;
    #1;
    check("mr_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    check("mr_calc_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mr_valid", 32'(bus.rsp_valid), 32'h0);
    check("mr_busy",  32'(bus.busy),      32'h0);
    tick();
    #1;
    check("mr_no_rsp", 32'(bus.rsp_valid), 32'h0);
    bus.req_valid = 4'b1010;
    bus.req_a     = 32'h00000600;
    bus.req_b     = 32'h00000700;
    #1;
    check("mr_grant_after", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    #1;
    check("mr_id", 32'(bus.rsp_id), 32'h1);
    check("mr_y",  32'(bus.rsp_y),  32'h002A);
    tick();

    // Skip: ptr=1; requester 1 in flight while 2 waits, then 2 drops as 3 raises.
    bus.req_valid = 4'b0010;
    bus.req_a     = 32'h00000200;
    bus.req_b     = 32'h00000300;
    tick();
    bus.req_valid = 4'b0100;
    tick();
    #1;
    check("sk_resp_ready", 32'(bus.req_ready), 32'h0);
    bus.req_valid = 4'b1000;
    bus.req_a     = 32'h0B000000;
    bus.req_b     = 32'h0D000000;
    tick();
    #1;
    check("sk_grant3", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    #1;
    check("sk_id", 32'(bus.rsp_id), 32'h3);
    check("sk_y",  32'(bus.rsp_y),  32'h008F);
    tick();

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
